ob_mk_queue: RTL and testbench

- Market-order queue for one side of the book (instantiated twice: buy and sell).
- Accepts market orders from the command decoder in arrival order.
- Presents the oldest order as a registered head entry with an empty flag to the market-trade controller.
- Retires the head or rewrites its quantity when the controller reports a trade outcome: full consumption, or partial fill with remainder.

---
 rtl/ob_pkg.sv | 15 +
 rtl/ob_mk_queue_fifo.sv | 42 ++++
 rtl/ob_mk_queue.sv | 90 +++++++++
 tb/tb_ob_mk_queue.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ob_pkg.sv
// ob_pkg: order-book shared types and the market-order queue depth.
package ob_pkg;
  localparam int UID_W = 16;
  localparam int PRICE_W = 16;
  localparam int QTY_W = 16;
  localparam int MK_QUEUE_N = 8;
  typedef logic [UID_W-1:0] uid_t;
  typedef logic [PRICE_W-1:0] price_t;
  typedef logic [QTY_W-1:0] quantity_t;
  typedef struct packed {
    uid_t      uid;
    price_t    price;
    quantity_t quantity;
  } table_t;
endpackage

// File: rtl/ob_mk_queue_fifo.sv
// ob_mk_queue_fifo: D-entry backing FIFO behind the head register; pointers wrap modulo D by compare.
// Ports: wr_en_i/wr_data_i write, rd_en_i advances the read pointer, rd_data_o shows the oldest entry, count_o is occupancy.
module ob_mk_queue_fifo
  import ob_pkg::*;
#(
  parameter int D = 7,
  parameter int PW = (D > 1) ? $clog2(D) : 1,
  parameter int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  table_t        wr_data_i,
  input  logic          rd_en_i,
  output table_t        rd_data_o,
  output logic [CW-1:0] count_o
);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  table_t mem_q [D];
  always_comb begin
    wr_ptr_d = wr_en_i ? ((wr_ptr_q == PW'(D - 1)) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = rd_en_i ? ((rd_ptr_q == PW'(D - 1)) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en_i) - CW'(rd_en_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
endmodule

// File: rtl/ob_mk_queue.sv
// ob_mk_queue: market-order queue for one book side with a registered head entry and trade retire/update path.
// Ports: push_vld/push_data/push_rdy enqueue; pop retires head; upd_vld/upd_quantity rewrite head quantity;
// head_r/empty_r/full_r/count_r/err_r are registered status, err_r is sticky until rst.
module ob_mk_queue
  import ob_pkg::*;
#(
  parameter int N = MK_QUEUE_N,
  parameter int W_CNT = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  table_t           push_data,
  output logic             push_rdy,
  input  logic             pop,
  input  logic             upd_vld,
  input  quantity_t        upd_quantity,
  output table_t           head_r,
  output logic             empty_r,
  output logic             full_r,
  output logic [W_CNT-1:0] count_r,
  output logic             err_r
);
  localparam int FCW = $clog2(N);
  table_t head_q, head_d, fifo_rd_data;
  logic [W_CNT-1:0] count_q, count_d;
  logic [FCW-1:0] fifo_cnt;
  logic empty_q, full_q, err_q, err_d;
  logic do_pop, do_upd, push_ok, fifo_wr, fifo_rd;
  // A zero-quantity update is a full consumption, so it retires like pop.
  assign do_pop  = (pop | (upd_vld & (upd_quantity == '0))) & ~empty_q;
  assign do_upd  = upd_vld & ~pop & (upd_quantity != '0) & ~empty_q;
  assign push_ok = push_vld & (~full_q | do_pop);
  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    if (push_ok && !do_pop) begin
      if (empty_q) head_d = push_data;
      else fifo_wr = 1'b1;
      count_d = count_q + W_CNT'(1);
    end else if (do_pop && !push_ok) begin
      if (fifo_cnt != '0) begin
        head_d  = fifo_rd_data;
        fifo_rd = 1'b1;
      end
      count_d = count_q - W_CNT'(1);
    end else if (do_pop && push_ok) begin
      if (count_q == W_CNT'(1)) head_d = push_data;
      else begin
        head_d  = fifo_rd_data;
        fifo_rd = 1'b1;
        fifo_wr = 1'b1;
      end
    end
    if (do_upd) head_d.quantity = upd_quantity;
    err_d = err_q | (pop & upd_vld) | ((pop | upd_vld) & empty_q) | (push_vld & full_q & ~do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      empty_q <= count_d == '0;
      full_q  <= count_d == W_CNT'(N);
      err_q   <= err_d;
    end
  end
  ob_mk_queue_fifo #(.D(N - 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (push_data),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rd_data),
    .count_o   (fifo_cnt)
  );
  assign head_r   = head_q;
  assign count_r  = count_q;
  assign empty_r  = empty_q;
  assign full_r   = full_q;
  assign err_r    = err_q;
  assign push_rdy = ~full_q;
endmodule

// File: tb/tb_ob_mk_queue.sv
// tb_ob_mk_queue: directed self-checking bench for ob_mk_queue.
module tb_ob_mk_queue;
  import ob_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic push_vld = 1'b0, pop = 1'b0, upd_vld = 1'b0, push_rdy, empty_r, full_r, err_r;
  table_t push_data = '0, head_r;
  quantity_t upd_quantity = '0;
  logic [3:0] count_r;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ob_mk_queue #(.N(8)) dut (
    .clk(clk), .rst(rst), .push_vld(push_vld), .push_data(push_data), .push_rdy(push_rdy),
    .pop(pop), .upd_vld(upd_vld), .upd_quantity(upd_quantity), .head_r(head_r),
    .empty_r(empty_r), .full_r(full_r), .count_r(count_r), .err_r(err_r)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic pv, input int uid, input int qty, input logic p, input logic u, input int uq);
    push_vld = pv;
    push_data = '{uid: uid_t'(uid), price: price_t'(100 + uid), quantity: quantity_t'(qty)};
    pop = p;
    upd_vld = u;
    upd_quantity = quantity_t'(uq);
    @(posedge clk);
    #1;
    push_vld = 1'b0;
    pop = 1'b0;
    upd_vld = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    do_reset();
    chk("rst_empty", 32'(empty_r), 1);
    chk("rst_count", 32'(count_r), 0);
    chk("rst_full", 32'(full_r), 0);
    chk("rst_err", 32'(err_r), 0);
    chk("rst_rdy", 32'(push_rdy), 1);
    chk("rst_head", 32'(head_r.uid), 0);
    step(1, 1, 10, 0, 0, 0);
    chk("bypass_uid", 32'(head_r.uid), 1);
    chk("bypass_qty", 32'(head_r.quantity), 10);
    chk("bypass_price", 32'(head_r.price), 101);
    chk("bypass_empty", 32'(empty_r), 0);
    chk("bypass_count", 32'(count_r), 1);
    for (int i = 2; i <= 8; i++) step(1, i, 10 * i, 0, 0, 0);
    chk("full_count", 32'(count_r), 8);
    chk("full_flag", 32'(full_r), 1);
    chk("full_rdy", 32'(push_rdy), 0);
    chk("full_err0", 32'(err_r), 0);
    step(1, 9, 90, 0, 0, 0);
    chk("ovf_err", 32'(err_r), 1);
    chk("ovf_count", 32'(count_r), 8);
    chk("ovf_head", 32'(head_r.uid), 1);
    step(1, 10, 100, 1, 0, 0);
    chk("fullpp_head", 32'(head_r.uid), 2);
    chk("fullpp_count", 32'(count_r), 8);
    for (int i = 3; i <= 8; i++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("drain_head", 32'(head_r.uid), i);
    end
    step(0, 0, 0, 1, 0, 0);
    chk("drain_last", 32'(head_r.uid), 10);
    chk("drain_last_qty", 32'(head_r.quantity), 100);
    do_reset();
    chk("rst2_err", 32'(err_r), 0);
    for (int i = 1; i <= 3; i++) step(1, i, 5, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("pop1_uid", 32'(head_r.uid), 2);
    chk("pop1_count", 32'(count_r), 2);
    step(0, 0, 0, 1, 0, 0);
    chk("pop2_uid", 32'(head_r.uid), 3);
    chk("pop2_count", 32'(count_r), 1);
    step(0, 0, 0, 1, 0, 0);
    chk("pop3_empty", 32'(empty_r), 1);
    chk("pop3_count", 32'(count_r), 0);
    chk("pop3_stale", 32'(head_r.uid), 3);
    chk("pop3_err", 32'(err_r), 0);
    step(0, 0, 0, 1, 0, 0);
    chk("popempty_err", 32'(err_r), 1);
    chk("popempty_count", 32'(count_r), 0);
    do_reset();
    step(1, 5, 10, 0, 0, 0);
    step(1, 6, 60, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4);
    chk("upd_qty", 32'(head_r.quantity), 4);
    chk("upd_uid", 32'(head_r.uid), 5);
    chk("upd_price", 32'(head_r.price), 105);
    chk("upd_count", 32'(count_r), 2);
    step(0, 0, 0, 0, 1, 0);
    chk("upd0_uid", 32'(head_r.uid), 6);
    chk("upd0_qty", 32'(head_r.quantity), 60);
    chk("upd0_count", 32'(count_r), 1);
    chk("upd0_err", 32'(err_r), 0);
    do_reset();
    step(1, 7, 70, 0, 0, 0);
    step(1, 9, 90, 1, 0, 0);
    chk("pp1_uid", 32'(head_r.uid), 9);
    chk("pp1_count", 32'(count_r), 1);
    chk("pp1_empty", 32'(empty_r), 0);
    step(1, 11, 110, 0, 0, 0);
    step(1, 12, 120, 1, 0, 0);
    chk("pp2_uid", 32'(head_r.uid), 11);
    chk("pp2_count", 32'(count_r), 2);
    chk("pp2_err", 32'(err_r), 0);
    step(0, 0, 0, 1, 1, 4);
    chk("popupd_uid", 32'(head_r.uid), 12);
    chk("popupd_qty", 32'(head_r.quantity), 120);
    chk("popupd_count", 32'(count_r), 1);
    chk("popupd_err", 32'(err_r), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
